// File: rtl/piso_shift_register.sv
// Parallel-in, serial-out shift register: captures a word on load, then emits
// it one bit per clock on serial_out in the configured bit order.
module piso_shift_register #(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic FILL      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out
);

  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;

  // Load takes priority; otherwise shift toward the output tap and fill the vacated end.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = parallel_in;
    end else if (MSB_FIRST) begin
      shreg_d = {shreg_q[WIDTH-2:0], FILL};
    end else begin
      shreg_d = {FILL, shreg_q[WIDTH-1:1]};
    end
  end

  // Shift register state with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= {WIDTH{1'b0}};
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign serial_out = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench: MSB-first and LSB-first instances driven in parallel and
// compared against a queue-based model of the bits still waiting to be sent.
module tb_piso_shift_register;

  localparam int   WIDTH = 8;
  localparam logic FILL  = 1'b0;

  logic             clk;
  logic             rst;
  logic             load;
  logic [WIDTH-1:0] parallel_in;
  logic             serial_out_msb;
  logic             serial_out_lsb;

  int total;
  int bad;

  // Model: each queue holds the bits not yet presented, front = current bit.
  logic q_msb[$];
  logic q_lsb[$];

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .FILL(FILL)) dut_msb (
    .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in), .serial_out(serial_out_msb)
  );

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .FILL(FILL)) dut_lsb (
    .clk(clk), .rst(rst), .load(load), .parallel_in(parallel_in), .serial_out(serial_out_lsb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic exp_bit(input logic front, input int size);
    return (size > 0) ? front : FILL;
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag);
    logic em;
    logic el;
    em = (q_msb.size() > 0) ? q_msb[0] : FILL;
    el = (q_lsb.size() > 0) ? q_lsb[0] : FILL;
    check({tag, "_msb"}, serial_out_msb, em);
    check({tag, "_lsb"}, serial_out_lsb, el);
  endtask

  task automatic model_edge(input logic ld, input logic [WIDTH-1:0] data);
    if (ld) begin
      q_msb.delete();
      q_lsb.delete();
      for (int i = 0; i < WIDTH; i++) begin
        q_msb.push_back(data[WIDTH-1-i]);
        q_lsb.push_back(data[i]);
      end
    end else begin
      if (q_msb.size() > 0) void'(q_msb.pop_front());
      if (q_lsb.size() > 0) void'(q_lsb.pop_front());
    end
  endtask

  task automatic step(input string tag, input logic ld, input logic [WIDTH-1:0] data);
    load        = ld;
    parallel_in = data;
    @(posedge clk);
    model_edge(ld, data);
    #1;
    load = 1'b0;
    check_both(tag);
  endtask

  // Reset pulse placed between clock edges; called 1 time unit after a rising edge.
  task automatic reset_pulse(input string tag);
    #3;
    rst = 1'b1;
    q_msb.delete();
    q_lsb.delete();
    #1;
    check({tag, "_msb"}, serial_out_msb, 1'b0);
    check({tag, "_lsb"}, serial_out_lsb, 1'b0);
    #2;
    rst = 1'b0;
  endtask

  logic [WIDTH-1:0] word;
  logic [7:0]       seq_exp;

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    load        = 1'b0;
    parallel_in = {WIDTH{1'b0}};

    // 1. Reset
    #2;
    check("rst_during_msb", serial_out_msb, 1'b0);
    check("rst_during_lsb", serial_out_lsb, 1'b0);
    #8;
    rst = 1'b0;
    #1;
    check("rst_release_msb", serial_out_msb, 1'b0);
    check("rst_release_lsb", serial_out_lsb, 1'b0);
    repeat (3) step("rst_idle", 1'b0, 8'h00);

    // 2/3. Serialise 8'b11010110 both orders, checked against literal sequences too
    word = 8'b11010110;
    step("ser_load", 1'b1, word);
    seq_exp = 8'b11010110;
    check("ser_msb_lit0", serial_out_msb, seq_exp[7]);
    seq_exp = 8'b01101011;
    check("ser_lsb_lit0", serial_out_lsb, seq_exp[7]);
    for (int k = 1; k < WIDTH; k++) begin
      step("ser_shift", 1'b0, 8'h00);
      seq_exp = 8'b11010110;
      check("ser_msb_lit", serial_out_msb, seq_exp[7-k]);
      seq_exp = 8'b01101011;
      check("ser_lsb_lit", serial_out_lsb, seq_exp[7-k]);
    end
    for (int k = 0; k < 4; k++) begin
      step("ser_drained", 1'b0, 8'h00);
      check("ser_fill_msb", serial_out_msb, FILL);
    end

    // 4. Reload mid-shift
    step("reload_ff", 1'b1, 8'hFF);
    check("reload_ff_msb", serial_out_msb, 1'b1);
    repeat (3) begin
      step("reload_shift", 1'b0, 8'h00);
      check("reload_one_msb", serial_out_msb, 1'b1);
    end
    step("reload_00", 1'b1, 8'h00);
    repeat (WIDTH + 2) begin
      step("reload_after", 1'b0, 8'h00);
      check("reload_zero_msb", serial_out_msb, 1'b0);
      check("reload_zero_lsb", serial_out_lsb, 1'b0);
    end

    // 5. Async reset mid-shift
    step("arst_load", 1'b1, 8'b10101010);
    check("arst_load_msb", serial_out_msb, 1'b1);
    step("arst_shift1", 1'b0, 8'h00);
    step("arst_shift2", 1'b0, 8'h00);
    check("arst_pre_msb", serial_out_msb, 1'b1);
    reset_pulse("arst_drop");
    repeat (WIDTH) begin
      step("arst_after", 1'b0, 8'h00);
      check("arst_zero_msb", serial_out_msb, 1'b0);
    end

    // 6. Held load
    repeat (4) begin
      step("held_load", 1'b1, 8'h80);
      check("held_one_msb", serial_out_msb, 1'b1);
      check("held_zero_lsb", serial_out_lsb, 1'b0);
    end
    repeat (3) begin
      step("held_release", 1'b0, 8'h00);
      check("held_drop_msb", serial_out_msb, 1'b0);
    end

    // Randomised traffic with occasional loads and reset pulses
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        reset_pulse("rand_rst");
        step("rand_post_rst", 1'b0, 8'h00);
      end else begin
        step("rand", ($urandom_range(0, 5) == 0), WIDTH'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
